// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   DATA_W    : operand width (only 8 is supported by the 9-bit adder)
//   ITER      : number of ADD/SHIFT iterations per multiply
//   LAST_ITER : index of the final iteration (the one that subtracts)
//   CNT_W     : width of the iteration counter
//   state_t   : FSM state encoding
package mult_pkg;

  localparam int DATA_W    = 8;
  localparam int ITER      = DATA_W;
  localparam int LAST_ITER = DATA_W - 1;
  localparam int CNT_W     = $clog2(ITER);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_ITER);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/add_sub_9.sv
// 9-bit add/subtract unit built from 4-bit ripple adder slices.
//   ripple_adder_4 : a[3:0] + b[3:0] + cin -> s[3:0], cout
//   add_sub_9      : s = a + (b ^ {9{sub}}) + sub  (a - b when sub=1)
// The carry out of bit 8 is discarded; operands are expected to be
// sign-extended by the caller so the 9-bit result is exact.

module ripple_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  always_comb begin
    logic [4:0] c;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

module add_sub_9 (
  input  logic [8:0] a,
  input  logic [8:0] b,
  input  logic       sub,
  output logic [8:0] s
);

  logic [8:0] b_x;
  logic       c4;
  logic       c8;

  // Two's complement subtract: invert b and inject the +1 as carry-in.
  assign b_x = b ^ {9{sub}};

  ripple_adder_4 u_lo (
    .a    (a[3:0]),
    .b    (b_x[3:0]),
    .cin  (sub),
    .s    (s[3:0]),
    .cout (c4)
  );

  ripple_adder_4 u_hi (
    .a    (a[7:4]),
    .b    (b_x[7:4]),
    .cin  (c4),
    .s    (s[7:4]),
    .cout (c8)
  );

  // Sign-extension bit; its carry out is intentionally dropped.
  assign s[8] = a[8] ^ b_x[8] ^ c8;

endmodule

// File: rtl/shift_add_multiplier_8.sv
// Sequential 8x8 signed shift-add multiplier (Moore FSM).
//   Clk          : clock, rising edge
//   Reset        : asynchronous active-high reset, clears all state
//   Run          : start request (level), only acted on in IDLE
//   ClearA_LoadB : in IDLE, clears A and X and loads B from S
//   S            : multiplicand at start / multiplier at load
//   Aval, Bval   : product registers {A,B} (B also holds the multiplier)
//   Xval         : sign-extension bit X
//   busy         : high in ADD and SHIFT
//   done         : high in DONE
//   state_dbg    : current FSM state (mult_pkg::state_t encoding)
// Handshake: Run is a level request; it starts a multiply when sampled
// high in IDLE, and DONE is left only once Run is seen low, so a held
// button yields exactly one multiply. No input combinationally reaches
// any output; busy/done are registered alongside the state.

module shift_add_multiplier_8
  import mult_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Xval,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   m_reg;
  logic               x_reg;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum;
  logic               sub;

  // The multiplier's MSB has negative weight, so the last partial
  // product is subtracted instead of added.
  assign sub = (cnt == LAST_CNT);

  add_sub_9 u_add_sub (
    .a   ({a_reg[WIDTH-1], a_reg}),
    .b   ({m_reg[WIDTH-1], m_reg}),
    .sub (sub),
    .s   (sum)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      m_reg <= '0;
      x_reg <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            m_reg <= S;
            a_reg <= '0;
            x_reg <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end else if (ClearA_LoadB) begin
            a_reg <= '0;
            x_reg <= 1'b0;
            b_reg <= S;
          end
        end
        ADD: begin
          if (b_reg[0]) begin
            a_reg <= sum[WIDTH-1:0];
            x_reg <= sum[WIDTH];
          end
          state <= SHIFT;
        end
        SHIFT: begin
          // Arithmetic right shift of {X,A,B}; X replicates itself.
          a_reg <= {x_reg, a_reg[WIDTH-1:1]};
          b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
          if (cnt == LAST_CNT) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
        DONE: begin
          if (!Run) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign Aval      = a_reg;
  assign Bval      = b_reg;
  assign Xval      = x_reg;
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_add_multiplier_8.sv
// Self-checking bench for shift_add_multiplier_8: directed cases plus
// randomized loads/multiplies checked against a signed-arithmetic model.

module tb_shift_add_multiplier_8;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] S;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       Xval;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [7:0]  b_model;      // what register B should currently hold
  logic [16:0] exp_q[$];     // {X, product} per started multiply

  shift_add_multiplier_8 dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .S            (S),
    .Aval         (Aval),
    .Bval         (Bval),
    .Xval         (Xval),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain signed multiplication of the two operands.
  function automatic logic [16:0] ref_mult(input logic [7:0] m, input logic [7:0] q);
    int          p;
    logic [31:0] p_bits;
    p      = int'($signed(m)) * int'($signed(q));
    p_bits = p;
    return {(p < 0), p_bits[15:0]};
  endfunction

  // ---------------- drivers ----------------
  task automatic load_b(input logic [7:0] v);
    @(negedge Clk);
    S            = v;
    ClearA_LoadB = 1'b1;
    @(posedge Clk); #1;
    ClearA_LoadB = 1'b0;
    b_model      = v;
    check("load_b", Bval, v);
    check("load_a", Aval, 8'h00);
  endtask

  // Starts a multiply of s_val by the current B, optionally disturbing
  // inputs while busy and holding Run through DONE for hold cycles.
  task automatic run_mult(input logic [7:0] s_val, input bit disturb, input int hold);
    logic [16:0] exp;
    int edges;
    int busy_n;
    exp_q.push_back(ref_mult(s_val, b_model));
    @(negedge Clk);
    S      = s_val;
    Run    = 1'b1;
    edges  = 0;
    busy_n = 0;
    do begin
      @(posedge Clk); #1;
      edges++;
      if (busy) busy_n++;
      if (!done && disturb) begin
        ClearA_LoadB = 1'($urandom_range(0, 1));
        S            = 8'($urandom);
      end
    end while (!done && edges < 40);
    ClearA_LoadB = 1'b0;
    check("latency", edges, 17);
    check("busy_cycles", busy_n, 16);
    exp = exp_q.pop_front();
    check("product", {Aval, Bval}, {16'h0, exp[15:0]});
    check("x_bit", Xval, exp[16]);
    b_model = exp[7:0];
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      check("hold_done", done, 1'b1);
      check("hold_product", {Aval, Bval}, {16'h0, exp[15:0]});
    end
    @(negedge Clk);
    Run = 1'b0;
    @(posedge Clk); #1;
    check("release_done", done, 1'b0);
    check("release_busy", busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    Reset        = 1'b1;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    S            = 8'h00;
    b_model      = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_a", Aval, 8'h00);
    check("rst_b", Bval, 8'h00);
    check("rst_x", Xval, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;

    // 7 * -59 = -413, held Run for 10 cycles, then chain *2.
    load_b(8'h07);
    run_mult(8'hC5, 1'b0, 10);
    check("tp1_const", {Aval, Bval}, 32'h0000FE63);
    check("tp1_x", Xval, 1'b1);
    run_mult(8'h02, 1'b0, 0);
    check("chain_const", {Aval, Bval}, 32'h000000C6);

    // -1 * -1 exercises the final subtract.
    load_b(8'hFF);
    run_mult(8'hFF, 1'b0, 0);
    check("m1m1_const", {Aval, Bval}, 32'h00000001);

    // -128 * -128 = +16384.
    load_b(8'h80);
    run_mult(8'h80, 1'b0, 0);
    check("min_min_const", {Aval, Bval}, 32'h00004000);
    check("min_min_x", Xval, 1'b0);

    // Inputs toggled while busy must not affect the result.
    load_b(8'hB3);
    run_mult(8'h5D, 1'b1, 0);

    // Randomized: fresh loads or chaining, some with disturbance.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) != 0) load_b(8'($urandom));
      run_mult(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a SHIFT state.
    load_b(8'h5A);
    @(negedge Clk);
    S      = 8'h33;
    Run    = 1'b1;
    waited = 0;
    do begin
      @(posedge Clk); #1;
      waited++;
    end while (!(state_dbg == mult_pkg::SHIFT && waited > 4) && waited < 40);
    check("reach_shift", state_dbg, mult_pkg::SHIFT);
    #2 Reset = 1'b1;
    #1;
    check("arst_a", Aval, 8'h00);
    check("arst_b", Bval, 8'h00);
    check("arst_x", Xval, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_state", state_dbg, mult_pkg::IDLE);
    Run     = 1'b0;
    b_model = 8'h00;
    @(negedge Clk);
    Reset = 1'b0;

    load_b(8'h03);
    run_mult(8'h05, 1'b0, 0);
    check("post_rst_const", {Aval, Bval}, 32'h0000000F);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
